rob_pr_free_distributor: RTL and testbench
==========================================

ROB_PR_FREE_DISTRIBUTOR -- requirements
Module: rob_pr_free_distributor

Interface
REQ-001 SHALL have parameter ENTRIES, default 2: bundle-queue depth.
REQ-002 SHALL have parameter LANES, default 4: freed-PR lanes per bundle.
REQ-003 SHALL have parameter PR_WIDTH, default 7: PR index width, log2(PR_COUNT=128).
REQ-004 SHALL have parameter BANKS, default 4: free-list banks, where bank = PR[1:0].
REQ-005 SHALL have port CLK, input, 1: the only clock.
REQ-006 SHALL have port nRST, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port enq_valid, input, 1: ROB offers a freed-PR bundle.
REQ-008 SHALL have port enq_valid_mask, input, LANES: per-lane freed-PR valid.
REQ-009 SHALL have port enq_PR_by_lane, input, LANES x PR_WIDTH: freed PR per lane.
REQ-010 SHALL have port enq_ready, output, 1: queue can accept a bundle.
REQ-011 SHALL have port free_valid_by_bank, output, BANKS: PR presented to that bank.
REQ-012 SHALL have port free_PR_by_bank, output, BANKS x PR_WIDTH: PR presented per bank.
REQ-013 SHALL have port free_ready_by_bank, input, BANKS: the free-list bank accepts.

Function
REQ-014 SHALL store up to ENTRIES bundles in a circular FIFO with head/tail pointers that wrap modulo ENTRIES, plus a separate full/empty indication.
REQ-015 SHALL assert enq_ready = !full, independent of same-cycle dequeue (no full-queue bypass).
REQ-016 SHALL write a bundle at the tail on enq_valid && enq_ready && (enq_valid_mask != 0).
REQ-017 SHALL drop a bundle with an all-zero mask without storing it; it does not advance tail.
REQ-018 SHALL ignore enq_valid while full; the input is not stored.
REQ-019 SHALL keep a per-bundle remaining mask at the head, loaded from the stored mask.
REQ-020 SHALL, for each bank b, select the lowest-indexed remaining head lane whose PR[1:0] == b.
REQ-021 SHALL drive free_valid_by_bank[b] = 1 and free_PR_by_bank[b] = that lane's PR when a lane is selected for bank b; otherwise free_valid_by_bank[b] = 0 and free_PR_by_bank[b] = 0.
REQ-022 SHALL drive the outputs combinationally from head state; a bundle enqueued in cycle N is presented no earlier than N+1.
REQ-023 SHALL clear a lane from the remaining mask on free_valid_by_bank[b] && free_ready_by_bank[b] for its bank.
REQ-024 SHALL serve lanes that map to the same bank one per cycle, in ascending lane order.
REQ-025 SHALL, when every remaining lane is handshaken in a cycle, advance head at that clock edge and present the next bundle's lanes in the following cycle.
REQ-026 SHALL allow enqueue and dequeue in the same cycle, with the count unchanged; the full/empty indication is updated correctly on wrap-around.
REQ-027 SHALL drive all free_valid_by_bank to 0 when empty, regardless of free_ready_by_bank.
REQ-028 SHALL never present a PR twice and never drop a stored valid lane.

Reset
REQ-029 SHALL, while nRST = 0, asynchronously clear head, tail, full, and all remaining masks.
REQ-030 SHALL, after reset, hold enq_ready = 1, free_valid_by_bank = 0, and free_PR_by_bank = 0.
REQ-031 SHALL discard all queued bundles, including any partially served head, on reset mid-operation; no output appears until a new bundle is enqueued.

Verification
REQ-032 SHALL cover the distinct-bank case: enqueue mask 4'b1111 with PRs {0x03, 0x02, 0x01, 0x00} on lanes 3..0, all readies 1 -> next cycle all four banks valid with PR 0x00/0x01/0x02/0x03 on banks 0..3; the queue is empty one cycle later.
REQ-033 SHALL cover the bank-conflict case: mask 4'b0111 with lanes 0..2 = {0x04, 0x08, 0x0D}, readies 1 -> cycle 1: bank0 = 0x04 and bank1 = 0x0D; cycle 2: bank0 = 0x08; the bundle retires after cycle 2.
REQ-034 SHALL cover backpressure: free_ready_by_bank = 0 with 2 bundles enqueued -> enq_ready = 0, the third enqueue is ignored, and outputs stay stable; raising the readies drains both bundles in order.
REQ-035 SHALL cover the zero-mask case: enq_valid = 1 with mask 0 -> nothing is stored, enq_ready stays 1, and no output appears.
REQ-036 SHALL cover wrap-around with simultaneous events: a continuous enqueue each cycle with readies 1 across 6 bundles -> every PR is emitted exactly once, in order, with pointers wrapping.
REQ-037 SHALL cover reset mid-drain: nRST is pulsed low while the head is half served -> outputs go to 0 immediately and enq_ready = 1.

Source files
------------

// File: rtl/rob_pr_free_distributor.sv
// Purpose: queue freed-PR bundles from the ROB and fan each head lane out to its free-list bank (bank = PR[1:0]).
// Latency: a bundle accepted in cycle N is presented in N+1; same-bank lanes drain one per cycle, lowest lane first.
// Backpressure: enq_ready = !full (no bypass when full); per-bank valid/ready; head retires once every lane is handshaken.
//
// Ports:
//   CLK, nRST            - clock, asynchronous active-low reset
//   enq_valid            - ROB offers a bundle this cycle
//   enq_valid_mask       - per-lane freed-PR valid (an all-zero mask is dropped)
//   enq_PR_by_lane       - freed PR per lane, lane i at [i*PR_WIDTH +: PR_WIDTH]
//   enq_ready            - queue has a free slot
//   free_valid_by_bank   - a PR is presented to bank b
//   free_PR_by_bank      - PR presented to bank b, at [b*PR_WIDTH +: PR_WIDTH]; 0 when not valid
//   free_ready_by_bank   - bank b accepts the presented PR
module rob_pr_free_distributor #(
  parameter int ENTRIES  = 2,
  parameter int LANES    = 4,
  parameter int PR_WIDTH = 7,
  parameter int BANKS    = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         enq_valid,
  input  logic [LANES-1:0]             enq_valid_mask,
  input  logic [LANES*PR_WIDTH-1:0]    enq_PR_by_lane,
  output logic                         enq_ready,
  output logic [BANKS-1:0]             free_valid_by_bank,
  output logic [BANKS*PR_WIDTH-1:0]    free_PR_by_bank,
  input  logic [BANKS-1:0]             free_ready_by_bank
);

  // BANKS is expected to be a power of two >= 2 so the bank is a plain low-bit slice of the PR.
  localparam int PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef logic [LANES-1:0][PR_WIDTH-1:0] lane_prs_t;

  // Queue storage: PRs need no reset, the remaining masks do (they define occupancy of each lane).
  lane_prs_t        pr_mem   [ENTRIES];
  logic [LANES-1:0] rem_mask [ENTRIES];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             empty;

  lane_prs_t        enq_prs;
  lane_prs_t        head_prs;
  logic [LANES-1:0] head_rem;
  logic [LANES-1:0] head_rem_next;
  logic [LANES-1:0] clr_mask;

  logic [BANKS-1:0][LANES-1:0] grant;
  logic [BANKS-1:0]            taken;

  logic enq;
  logic deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign enq_prs  = enq_PR_by_lane;
  assign head_prs = pr_mem[head];
  assign head_rem = rem_mask[head];

  // head == tail is ambiguous on its own; the full flag disambiguates.
  assign empty     = (head == tail) && !full;
  assign enq_ready = !full;

  // Zero-mask bundles are swallowed here so they never occupy a slot.
  assign enq = enq_valid && !full && (|enq_valid_mask);

  // Per-bank priority pick: the lowest remaining lane whose PR maps to the bank.
  always_comb begin
    grant = '0;
    taken = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int i = 0; i < LANES; i++) begin
        if (!empty && head_rem[i] && !taken[b] &&
            (head_prs[i][BANK_W-1:0] == BANK_W'(b))) begin
          grant[b][i] = 1'b1;
          taken[b]    = 1'b1;
        end
      end
    end
  end

  // grant is one-hot per bank, so a plain priority-free mux is enough.
  always_comb begin
    free_valid_by_bank = '0;
    free_PR_by_bank    = '0;
    for (int b = 0; b < BANKS; b++) begin
      free_valid_by_bank[b] = |grant[b];
      for (int i = 0; i < LANES; i++) begin
        if (grant[b][i]) begin
          free_PR_by_bank[b*PR_WIDTH +: PR_WIDTH] = head_prs[i];
        end
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (free_valid_by_bank[b] && free_ready_by_bank[b]) begin
        clr_mask = clr_mask | grant[b];
      end
    end
  end

  assign head_rem_next = head_rem & ~clr_mask;

  // Stored bundles always have a non-zero mask, so an empty remainder means the head is done.
  assign deq = !empty && (head_rem_next == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
      full <= 1'b0;
      for (int e = 0; e < ENTRIES; e++) begin
        rem_mask[e] <= '0;
      end
    end else begin
      // head and tail only alias when empty (no head update) or full (no enqueue).
      if (!empty) begin
        rem_mask[head] <= head_rem_next;
      end
      if (enq) begin
        rem_mask[tail] <= enq_valid_mask;
        tail           <= ptr_inc(tail);
      end
      if (deq) begin
        head <= ptr_inc(head);
      end
      if (enq && !deq) begin
        full <= (ptr_inc(tail) == head);
      end else if (deq && !enq) begin
        full <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      pr_mem[tail] <= enq_prs;
    end
  end

endmodule

// File: tb/tb_rob_pr_free_distributor.sv
module tb_rob_pr_free_distributor;

  localparam int ENTRIES = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        enq_valid;
  logic [3:0]  enq_valid_mask;
  logic [27:0] enq_PR_by_lane;
  logic        enq_ready;
  logic [3:0]  free_valid_by_bank;
  logic [27:0] free_PR_by_bank;
  logic [3:0]  free_ready_by_bank;

  always #5 CLK = ~CLK;

  rob_pr_free_distributor #(
    .ENTRIES(ENTRIES), .LANES(4), .PR_WIDTH(7), .BANKS(4)
  ) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .enq_valid          (enq_valid),
    .enq_valid_mask     (enq_valid_mask),
    .enq_PR_by_lane     (enq_PR_by_lane),
    .enq_ready          (enq_ready),
    .free_valid_by_bank (free_valid_by_bank),
    .free_PR_by_bank    (free_PR_by_bank),
    .free_ready_by_bank (free_ready_by_bank)
  );

  // Reference: a queue of bundles, each holding the lanes still waiting to be freed.
  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][6:0] pr;
  } bund_t;

  bund_t mq[$];
  int checks = 0;
  int failures = 0;
  int tot_in = 0;
  int tot_out = 0;
  int tot_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected bank outputs: lowest remaining head lane whose PR mod 4 equals the bank.
  function automatic void model_out(output logic [3:0] ev, output logic [27:0] epr);
    ev  = '0;
    epr = '0;
    if (mq.size() > 0) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 4; i++) begin
          if (!ev[b] && mq[0].mask[i] && (int'(mq[0].pr[i]) % 4 == b)) begin
            ev[b] = 1'b1;
            epr[b*7 +: 7] = mq[0].pr[i];
          end
        end
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [3:0] m, input logic [27:0] p, input logic [3:0] r);
    enq_valid          = v;
    enq_valid_mask     = m;
    enq_PR_by_lane     = p;
    free_ready_by_bank = r;
  endtask

  // One clock cycle: compare at negedge, advance the reference at posedge, return at posedge+1.
  task automatic step();
    logic [3:0]  ev;
    logic [27:0] epr;
    bit          rdy;
    bit          done;
    bund_t       h;
    bund_t       nb;
    model_out(ev, epr);
    rdy = (mq.size() < ENTRIES);
    @(negedge CLK);
    chk("enq_ready", 32'(enq_ready), 32'(rdy));
    chk("free_valid", 32'(free_valid_by_bank), 32'(ev));
    chk("free_pr", 32'(free_PR_by_bank), 32'(epr));
    for (int b = 0; b < 4; b++) begin
      if (free_valid_by_bank[b] && free_ready_by_bank[b]) tot_out++;
    end
    @(posedge CLK);
    if (mq.size() > 0) begin
      h = mq[0];
      for (int b = 0; b < 4; b++) begin
        if (ev[b] && free_ready_by_bank[b]) begin
          done = 1'b0;
          for (int i = 0; i < 4; i++) begin
            if (!done && h.mask[i] && (int'(h.pr[i]) % 4 == b)) begin
              h.mask[i] = 1'b0;
              done = 1'b1;
            end
          end
        end
      end
      if (h.mask == '0) void'(mq.pop_front());
      else mq[0] = h;
    end
    if (enq_valid && rdy && (enq_valid_mask != '0)) begin
      nb.mask = enq_valid_mask;
      nb.pr   = enq_PR_by_lane;
      mq.push_back(nb);
      tot_in += $countones(enq_valid_mask);
    end
    #1;
  endtask

  initial begin
    logic [27:0] p;
    int n;
    drive(1'b0, 4'h0, 28'h0, 4'hF);

    // Reset state
    @(posedge CLK); #1;
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_valid", 32'(free_valid_by_bank), 32'd0);
    chk("rst_pr", 32'(free_PR_by_bank), 32'd0);
    nRST = 1'b1;
    step();

    // Distinct banks: one bundle drains in a single cycle
    drive(1'b1, 4'hF, {7'h03, 7'h02, 7'h01, 7'h00}, 4'hF);
    step();
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    chk("distinct_valid", 32'(free_valid_by_bank), 32'hF);
    p = {7'h03, 7'h02, 7'h01, 7'h00};
    chk("distinct_pr", 32'(free_PR_by_bank), 32'(p));
    step();
    chk("distinct_empty", 32'(free_valid_by_bank), 32'd0);
    step();

    // Bank conflict: lanes 0 and 1 both hit bank 0
    drive(1'b1, 4'b0111, {7'h00, 7'h0D, 7'h08, 7'h04}, 4'hF);
    step();
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    chk("conflict_c1_valid", 32'(free_valid_by_bank), 32'h3);
    p = {7'h00, 7'h00, 7'h0D, 7'h04};
    chk("conflict_c1_pr", 32'(free_PR_by_bank), 32'(p));
    step();
    chk("conflict_c2_valid", 32'(free_valid_by_bank), 32'h1);
    p = {7'h00, 7'h00, 7'h00, 7'h08};
    chk("conflict_c2_pr", 32'(free_PR_by_bank), 32'(p));
    step();
    chk("conflict_retired", 32'(free_valid_by_bank), 32'd0);
    step();

    // Backpressure: fill the queue, third offer is ignored
    drive(1'b1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h11}, 4'h0);
    step();
    drive(1'b1, 4'b0011, {7'h00, 7'h00, 7'h33, 7'h22}, 4'h0);
    step();
    drive(1'b1, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h44}, 4'h0);
    chk("bp_full_ready", 32'(enq_ready), 32'd0);
    step();
    drive(1'b0, 4'h0, 28'h0, 4'h0);
    step();
    chk("bp_hold_valid", 32'(free_valid_by_bank), 32'h2);
    p = {7'h00, 7'h00, 7'h11, 7'h00};
    chk("bp_hold_pr", 32'(free_PR_by_bank), 32'(p));
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    step();
    chk("bp_second_valid", 32'(free_valid_by_bank), 32'hC);
    step();
    chk("bp_drained", 32'(free_valid_by_bank), 32'd0);
    step();

    // Zero mask is dropped
    drive(1'b1, 4'h0, 28'($urandom), 4'hF);
    step();
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    chk("zero_mask_ready", 32'(enq_ready), 32'd1);
    chk("zero_mask_valid", 32'(free_valid_by_bank), 32'd0);
    step();

    // Continuous enqueue with simultaneous dequeue; pointers wrap several times
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) p[i*7 +: 7] = 7'(($urandom % 32) * 4 + i);
      drive(1'b1, 4'hF, p, 4'hF);
      step();
    end
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    for (int k = 0; k < 3; k++) step();

    // Reset while the head is half served
    drive(1'b1, 4'hF, {7'h0C, 7'h08, 7'h04, 7'h00}, 4'hF);
    step();
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    step();
    chk("midrst_before_pr", 32'(free_PR_by_bank), 32'h4);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_valid", 32'(free_valid_by_bank), 32'd0);
    chk("midrst_pr", 32'(free_PR_by_bank), 32'd0);
    chk("midrst_ready", 32'(enq_ready), 32'd1);
    foreach (mq[j]) tot_drop += $countones(mq[j].mask);
    mq.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
    step();
    step();

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0,
            (($urandom % 8) == 0) ? 4'h0 : 4'($urandom),
            28'($urandom),
            4'($urandom | $urandom));
      step();
    end
    drive(1'b0, 4'h0, 28'h0, 4'hF);
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
    step();
    chk("lane_conservation", 32'(tot_out), 32'(tot_in - tot_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
